// File: rtl/wlm_iter_red_pkg.sv
// Shared types and elaboration helpers for the word-level Montgomery reducer.
package wlm_iter_red_pkg;

  typedef struct packed {
    int logq;
    int logqh;
    int w;
    int niter;
    int nq;
    int correct;
  } wlm_params_t;

  function automatic int latency(wlm_params_t p);
    return 1 + p.niter + p.correct;
  endfunction

  function automatic int qsel_width(int nq);
    return (nq > 1) ? $clog2(nq) : 1;
  endfunction

  // Width of the value leaving iteration i (i = 0 is the raw product C).
  function automatic int stage_width(wlm_params_t p, int i);
    int sw;
    if (i == 0) return 2 * p.logq;
    sw = 2 * p.logq - i * p.w + 1;
    return (sw > p.logq + 2) ? sw : p.logq + 2;
  endfunction

  function automatic int qp_shift(int logq, int logqh, int w);
    return logq - logqh - w;
  endfunction

  function automatic bit iter_legal(wlm_params_t p);
    return (p.niter * p.w >= p.logq) && (p.w >= 1) && (p.w <= p.logq - p.logqh);
  endfunction

endpackage

// File: rtl/wlm_iter_stage.sv
// One registered Montgomery word iteration: next = CH + m*q' + (CL != 0).
module wlm_iter_stage
  import wlm_iter_red_pkg::*;
#(
  parameter int LOGQ  = 60,
  parameter int LOGQH = 17,
  parameter int W     = 43,
  parameter int IN_W  = 120,
  parameter int OUT_W = 78
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_x,
  input  logic [LOGQH-1:0] in_qh,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_x,
  output logic [LOGQH-1:0] out_qh
);

  localparam int QP_W  = LOGQ - W;
  localparam int QP_SH = qp_shift(LOGQ, LOGQH, W);

  logic [W-1:0]      cl;
  logic [W-1:0]      m;
  logic [IN_W-W-1:0] ch;
  logic [QP_W-1:0]   qp;
  logic [LOGQ-1:0]   prod;
  logic [OUT_W-1:0]  nxt;

  assign cl   = in_x[W-1:0];
  assign ch   = in_x[IN_W-1:W];
  assign m    = -cl;
  assign qp   = QP_W'(in_qh) << QP_SH;
  // m < 2^W and q' < 2^(LOGQ-W), so the product always fits in LOGQ bits.
  assign prod = LOGQ'(m) * LOGQ'(qp);
  assign nxt  = OUT_W'(ch) + OUT_W'(prod) + OUT_W'(cl != '0);

  // NOTE: clocked state uses <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_qh    <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_x  <= nxt;
        out_qh <= in_qh;
      end
    end
  end

endmodule

// File: rtl/wlm_iter_red.sv
// Pipelined word-level Montgomery reducer with a runtime modulus table and valid/ready flow.
// Optional macro WLM_ITER_RED_TAG_EN adds a TAG_W-bit sideband tag travelling with each operand.
module wlm_iter_red
  import wlm_iter_red_pkg::*;
#(
  parameter int LOGQ    = 60,
  parameter int LOGQH   = 17,
  parameter int W       = 43,
  parameter int NITER   = 2,
  parameter int NQ      = 4,
  parameter int CORRECT = 1,
`ifdef WLM_ITER_RED_TAG_EN
  parameter int TAG_W   = 8,
`endif
  localparam int QSEL_W = qsel_width(NQ),
  localparam int T_W    = (CORRECT != 0) ? LOGQ : LOGQ + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [QSEL_W-1:0] cfg_addr,
  input  logic [LOGQH-1:0]  cfg_qh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [QSEL_W-1:0] in_qsel,
  input  logic [2*LOGQ-1:0] in_c,
`ifdef WLM_ITER_RED_TAG_EN
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [T_W-1:0]    out_t
);

  localparam wlm_params_t P = '{logq: LOGQ, logqh: LOGQH, w: W, niter: NITER,
                                nq: NQ, correct: CORRECT};
  localparam int FIN_W = stage_width(P, NITER);
  localparam int QSH   = LOGQ - LOGQH;

  if (!iter_legal(P)) begin : g_illegal
    $error("wlm_iter_red: need NITER*W >= LOGQ and 1 <= W <= LOGQ-LOGQH");
  end

  logic en;
  logic accept;

  // A held output freezes the entire pipeline; bubbles stay where they are.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  logic [LOGQH-1:0] qh_tab [NQ];
  logic [LOGQH-1:0] qh_sel;

  // NOTE: the table is reset (unlike a RAM) because unprogrammed entries must read as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NQ; e++) qh_tab[e] <= '0;
    end else if (cfg_we) begin
      for (int e = 0; e < NQ; e++)
        if (cfg_addr == QSEL_W'(e)) qh_tab[e] <= cfg_qh;
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    qh_sel = '0;
    for (int e = 0; e < NQ; e++)
      if (in_qsel == QSEL_W'(e)) qh_sel = qh_tab[e];
  end

  logic              s0_valid;
  logic [2*LOGQ-1:0] s0_c;
  logic [LOGQH-1:0]  s0_qh;
  logic [NITER:0]    vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid <= 1'b0;
      s0_c     <= '0;
      s0_qh    <= '0;
    end else if (en) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_c  <= in_c;
        s0_qh <= qh_sel;
      end
    end
  end

  assign vld[0] = s0_valid;

  for (genvar i = 1; i <= NITER; i++) begin : g_iter
    localparam int SW_IN  = stage_width(P, i - 1);
    localparam int SW_OUT = stage_width(P, i);

    logic [SW_IN-1:0]  x_in;
    logic [LOGQH-1:0]  qh_in;
    logic [SW_OUT-1:0] x;
    logic [LOGQH-1:0]  qh;

    if (i == 1) begin : g_first
      assign x_in  = s0_c;
      assign qh_in = s0_qh;
    end else begin : g_next
      assign x_in  = g_iter[i-1].x;
      assign qh_in = g_iter[i-1].qh;
    end

    wlm_iter_stage #(
      .LOGQ (LOGQ),
      .LOGQH(LOGQH),
      .W    (W),
      .IN_W (SW_IN),
      .OUT_W(SW_OUT)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (vld[i-1]),
      .in_x     (x_in),
      .in_qh    (qh_in),
      .out_valid(vld[i]),
      .out_x    (x),
      .out_qh   (qh)
    );
  end

  if (CORRECT != 0) begin : g_corr
    logic [FIN_W-1:0] fin;
    logic [FIN_W-1:0] q_full;
    logic [FIN_W-1:0] sub;

    assign fin    = g_iter[NITER].x;
    assign q_full = (FIN_W'(g_iter[NITER].qh) << QSH) + FIN_W'(1);

    // The iterate is below 3q, so at most one of q or 2q needs removing.
    always_comb begin
      sub = '0;
      if (fin >= (q_full << 1)) sub = q_full << 1;
      else if (fin >= q_full)   sub = q_full;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_valid <= 1'b0;
        out_t     <= '0;
      end else if (en) begin
        out_valid <= vld[NITER];
        if (vld[NITER]) out_t <= T_W'(fin - sub);
      end
    end
  end else begin : g_raw
    assign out_valid = vld[NITER];
    assign out_t     = T_W'(g_iter[NITER].x);
  end

`ifdef WLM_ITER_RED_TAG_EN
  localparam int TAG_SLOTS = latency(P) - CORRECT;

  logic [TAG_W-1:0] tag_q [TAG_SLOTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAG_SLOTS; k++) tag_q[k] <= '0;
    end else if (en) begin
      if (in_valid) tag_q[0] <= in_tag;
      for (int k = 1; k < TAG_SLOTS; k++)
        if (vld[k-1]) tag_q[k] <= tag_q[k-1];
    end
  end

  if (CORRECT != 0) begin : g_tag_out
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  out_tag <= '0;
      else if (en && vld[NITER]) out_tag <= tag_q[NITER];
    end
  end else begin : g_tag_raw
    assign out_tag = tag_q[NITER];
  end
`endif

endmodule
